// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] R0 = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX writes a register the ID
// instruction reads, so ID must wait one cycle.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rs,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = ifid_uses_rs && (ifid_rs == idex_rd);
  assign rt_hit = ifid_uses_rt && (ifid_rt == idex_rd);

  // r0 is hardwired, so a load targeting it never creates a hazard
  assign load_use = idex_memread && (idex_rd != R0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline:
// load-use, branch squash, cache-miss stalls and HLT freeze.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rs,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             branch_taken,
  input  logic             imem_miss,
  input  logic             dmem_miss,
  input  logic             memwb_hlt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 2);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load_use;
  logic          take_br;

  hazard_detect u_hz (
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rs (ifid_uses_rs),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .load_use     (load_use)
  );

  // a load-use stall holds ID, so its branch decision is not final yet
  assign take_br = branch_taken && !load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      RUN: begin
        if (memwb_hlt) begin
          state_n = HALT;
        end else if (dmem_miss) begin
          state_n = DMISS;
          cnt_n   = CNT_LOAD;
        end else if (imem_miss && !take_br) begin
          state_n = IMISS;
          cnt_n   = CNT_LOAD;
        end
      end
      IMISS: begin
        if (take_br || cnt == '0) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DMISS: begin
        if (cnt == '0) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HALT: state_n = HALT;
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    idex_wen    = 1'b1;
    exmem_wen   = 1'b1;
    memwb_wen   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      memwb_wen   = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (memwb_hlt) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_wen = 1'b0;
          end else if (dmem_miss) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_wen    = 1'b0;
            exmem_wen   = 1'b0;
            memwb_flush = 1'b1;
          end else if (load_use) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end else if (imem_miss) begin
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        IMISS: begin
          if (load_use) begin
            pc_wen     = 1'b0;
            ifid_wen   = 1'b0;
            idex_flush = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
          end else begin
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        DMISS: begin
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_wen    = 1'b0;
          exmem_wen   = 1'b0;
          memwb_flush = 1'b1;
        end
        HALT: begin
          pc_wen    = 1'b0;
          ifid_wen  = 1'b0;
          idex_wen  = 1'b0;
          exmem_wen = 1'b0;
          memwb_wen = 1'b0;
          halted    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_wen && stall_cycles != {CNT_W{1'b1}}) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
